cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter: FIFO_DEPTH, 2, entries per requester queue (power of two, >=2).
REQ-002 Clocking: one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  system clock; all state on rising edge.
REQ-004 rst  in  1  asynchronous active-low reset.
REQ-005 rdy  in  1  global enable; low = freeze.
REQ-006 misbranch_flag  in  1  flush request from ROB.
REQ-007 arith_valid  in  1  Arith unit result offered.
REQ-008 arith_rob_id  in  ROB_ID_WIDTH(4)  destination ROB tag.
REQ-009 arith_result  in  32  result value.
REQ-010 arith_ready  out  1  Arith queue can accept this cycle.
REQ-011 ls_valid, ls_rob_id, ls_result, ls_ready: same widths and meaning for the LS unit.
REQ-012 cdb_valid  out  1  broadcast valid, registered.
REQ-013 cdb_rob_id  out  4  broadcast tag, registered.
REQ-014 cdb_result  out  32  broadcast value, registered.
REQ-015 cdb_src  out  1  0 = Arith, 1 = LS.

Function
REQ-016 Handshake: push on rising edge when X_valid & X_ready & rdy & !misbranch_flag; X_ready = rdy & (count_X < FIFO_DEPTH), combinational.
REQ-017 Input with rob_id == ZERO_ROB: handshake completes, entry discarded, never broadcast.
REQ-018 Each queue FIFO-ordered; head/tail pointers wrap modulo FIFO_DEPTH; count 0..FIFO_DEPTH.
REQ-019 Push and pop on the same queue in the same cycle are allowed; count unchanged.
REQ-020 Per cycle (rdy high): at most one head popped and registered onto cdb_* next edge; cdb_valid = 1 iff a pop occurred, else 0.
REQ-021 Latency: item pushed at edge N into an empty, uncontended queue broadcasts at edge N+1; combinational bypass of empty queue prohibited.
REQ-022 Arbitration: one nonempty -> grant it; both nonempty -> grant the requester not granted last (last_grant register, updated on every grant).
REQ-023 When cdb_valid = 0, cdb_rob_id, cdb_result, cdb_src hold prior values.
REQ-024 rdy low: no push, no pop, all state and outputs hold; X_ready = 0.
REQ-025 misbranch_flag high at an edge (regardless of rdy): both queues emptied, cdb_valid <= 0, last_grant <= LS; same-cycle inputs dropped.
REQ-026 Full queue: X_ready = 0 until a pop; offered data is not lost (requester holds).

Reset
REQ-027 rst low: counts, pointers = 0; cdb_valid = 0; cdb_rob_id = ZERO_ROB; cdb_result = 0; cdb_src = 0; last_grant = LS (Arith wins first contention).
REQ-028 Reset mid-operation discards all queued entries immediately; no broadcast until first post-reset push.

Structure
REQ-029 ROB_ID_TYPE, DATA_TYPE, ZERO_ROB, TRUE/FALSE, CDB_SRC_ARITH/CDB_SRC_LS reside in the shared constants file.
REQ-030 One sub-module cdb_fifo (parameterised depth, push/pop/flush, count, head data), instantiated twice.

Verification
REQ-031 Arith only: push tag 3 value 0x11 -> next edge cdb_valid=1, rob_id=3, result=0x11, src=0.
REQ-032 Same-cycle push Arith(tag1,0xA) and LS(tag2,0xB) after reset -> tag1 first (src=0), then tag2 (src=1), consecutive cycles.
REQ-033 Hold both valid 6 cycles with distinct tags -> strictly alternating src; Arith ready drops when its queue fills; no tag lost or duplicated.
REQ-034 Fill LS queue (2 entries), assert misbranch_flag -> next edge cdb_valid=0, ls_ready=1, nothing later broadcast.
REQ-035 Push tag 0 on Arith -> arith_ready=1 handshake, cdb_valid stays 0.
REQ-036 rdy low for 3 cycles with queued entries -> cdb_* frozen, readys 0; on rdy high, broadcast resumes in original order.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// cdb_arbiter_pkg
//   Shared constants and types for the common data bus (CDB) arbiter:
//   ROB tag and data types, the reserved "no destination" tag, boolean
//   constants, the CDB source encoding and the queued-entry layout.
// -----------------------------------------------------------------------------
package cdb_arbiter_pkg;

    localparam int ROB_ID_WIDTH = 4;
    localparam int DATA_WIDTH   = 32;

    typedef logic [ROB_ID_WIDTH-1:0] ROB_ID_TYPE;
    typedef logic [DATA_WIDTH-1:0]   DATA_TYPE;

    // Tag 0 marks a result with no ROB destination; it is accepted but dropped.
    localparam ROB_ID_TYPE ZERO_ROB = '0;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef enum logic {
        CDB_SRC_ARITH = 1'b0,
        CDB_SRC_LS    = 1'b1
    } cdb_src_e;

    typedef struct packed {
        ROB_ID_TYPE rob_id;
        DATA_TYPE   result;
    } cdb_entry_t;

endpackage

// File: rtl/cdb_fifo.sv
// -----------------------------------------------------------------------------
// cdb_fifo
//   Small circular FIFO holding results waiting for the CDB.
//   Ports:
//     clk, rst    clock, asynchronous active-low reset
//     push        write push_data at the tail (caller guarantees not full)
//     push_data   entry to enqueue
//     pop         drop the head entry (caller guarantees not empty)
//     flush       empty the queue; overrides push and pop
//     count       occupancy, 0..DEPTH
//     head        entry at the head (undefined while count == 0)
// -----------------------------------------------------------------------------
module cdb_fifo
    import cdb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  cdb_entry_t               push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output cdb_entry_t               head
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    cdb_entry_t       mem [DEPTH];

    // NOTE: the storage array has no reset; validity is tracked solely by
    // count and the pointers, so stale contents are never broadcast.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // DEPTH is a power of two, so pointer overflow is the modulo wrap.
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//   Collects results from the Arith and LS units into per-unit queues and
//   broadcasts at most one per cycle on the registered CDB, alternating
//   between the units under contention.
//   Ports:
//     clk, rst                 clock, asynchronous active-low reset
//     rdy                      global enable; low freezes everything
//     misbranch_flag           flush both queues (wins over rdy)
//     arith_valid/_rob_id/_result, arith_ready   Arith result handshake
//     ls_valid/_rob_id/_result, ls_ready         LS result handshake
//     cdb_valid/_rob_id/_result/_src             registered broadcast
// -----------------------------------------------------------------------------
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rdy,
    input  logic       misbranch_flag,

    input  logic       arith_valid,
    input  ROB_ID_TYPE arith_rob_id,
    input  DATA_TYPE   arith_result,
    output logic       arith_ready,

    input  logic       ls_valid,
    input  ROB_ID_TYPE ls_rob_id,
    input  DATA_TYPE   ls_result,
    output logic       ls_ready,

    output logic       cdb_valid,
    output ROB_ID_TYPE cdb_rob_id,
    output DATA_TYPE   cdb_result,
    output logic       cdb_src
);

    localparam int               CNT_W      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

    logic [CNT_W-1:0] arith_count;
    logic [CNT_W-1:0] ls_count;
    cdb_entry_t       arith_head;
    cdb_entry_t       ls_head;

    logic       arith_push;
    logic       ls_push;
    logic       grant_arith;
    logic       grant_ls;
    cdb_src_e   last_grant;

    assign arith_ready = rdy && (arith_count < FULL_COUNT);
    assign ls_ready    = rdy && (ls_count < FULL_COUNT);

    // Tag-0 results complete the handshake but are never enqueued.
    assign arith_push = arith_valid && arith_ready && !misbranch_flag &&
                        (arith_rob_id != ZERO_ROB);
    assign ls_push    = ls_valid && ls_ready && !misbranch_flag &&
                        (ls_rob_id != ZERO_ROB);

    // Arbitration looks only at stored entries, so a fresh push is never
    // bypassed straight onto the bus.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        grant_arith = FALSE;
        grant_ls    = FALSE;
        if (rdy && !misbranch_flag) begin
            if ((arith_count != '0) && (ls_count != '0)) begin
                if (last_grant == CDB_SRC_LS) begin
                    grant_arith = TRUE;
                end else begin
                    grant_ls = TRUE;
                end
            end else if (arith_count != '0) begin
                grant_arith = TRUE;
            end else if (ls_count != '0) begin
                grant_ls = TRUE;
            end
        end
    end

    cdb_fifo #(
        .DEPTH     (FIFO_DEPTH)
    ) u_arith_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (arith_push),
        .push_data ('{rob_id: arith_rob_id, result: arith_result}),
        .pop       (grant_arith),
        .flush     (misbranch_flag),
        .count     (arith_count),
        .head      (arith_head)
    );

    cdb_fifo #(
        .DEPTH     (FIFO_DEPTH)
    ) u_ls_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (ls_push),
        .push_data ('{rob_id: ls_rob_id, result: ls_result}),
        .pop       (grant_ls),
        .flush     (misbranch_flag),
        .count     (ls_count),
        .head      (ls_head)
    );

    // Broadcast register. Tag/result/src only change on a grant so they hold
    // their last broadcast while cdb_valid is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cdb_valid  <= FALSE;
            cdb_rob_id <= ZERO_ROB;
            cdb_result <= '0;
            cdb_src    <= CDB_SRC_ARITH;
            last_grant <= CDB_SRC_LS;
        end else if (misbranch_flag) begin
            cdb_valid  <= FALSE;
            last_grant <= CDB_SRC_LS;
        end else if (rdy) begin
            cdb_valid <= grant_arith || grant_ls;
            if (grant_arith) begin
                cdb_rob_id <= arith_head.rob_id;
                cdb_result <= arith_head.result;
                cdb_src    <= CDB_SRC_ARITH;
                last_grant <= CDB_SRC_ARITH;
            end else if (grant_ls) begin
                cdb_rob_id <= ls_head.rob_id;
                cdb_result <= ls_head.result;
                cdb_src    <= CDB_SRC_LS;
                last_grant <= CDB_SRC_LS;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_arbiter
//   Self-checking bench for cdb_arbiter. A behavioural queue model predicts
//   each edge; predicted broadcasts go into a scoreboard queue and are popped
//   and compared when the DUT drives them.
// -----------------------------------------------------------------------------
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int DEPTH = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       rdy;
    logic       misbranch_flag;
    logic       arith_valid;
    ROB_ID_TYPE arith_rob_id;
    DATA_TYPE   arith_result;
    logic       arith_ready;
    logic       ls_valid;
    ROB_ID_TYPE ls_rob_id;
    DATA_TYPE   ls_result;
    logic       ls_ready;
    logic       cdb_valid;
    ROB_ID_TYPE cdb_rob_id;
    DATA_TYPE   cdb_result;
    logic       cdb_src;

    cdb_arbiter #(
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .misbranch_flag (misbranch_flag),
        .arith_valid    (arith_valid),
        .arith_rob_id   (arith_rob_id),
        .arith_result   (arith_result),
        .arith_ready    (arith_ready),
        .ls_valid       (ls_valid),
        .ls_rob_id      (ls_rob_id),
        .ls_result      (ls_result),
        .ls_ready       (ls_ready),
        .cdb_valid      (cdb_valid),
        .cdb_rob_id     (cdb_rob_id),
        .cdb_result     (cdb_result),
        .cdb_src        (cdb_src)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        ROB_ID_TYPE rob_id;
        DATA_TYPE   result;
        logic       src;
    } bcast_t;

    localparam logic SRC_A = CDB_SRC_ARITH;
    localparam logic SRC_L = CDB_SRC_LS;

    bcast_t mq_a[$];
    bcast_t mq_ls[$];
    bcast_t exp_q[$];
    logic   m_last_ls;
    logic   m_valid;
    bcast_t m_held;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mq_a.delete();
        mq_ls.delete();
        exp_q.delete();
        m_last_ls = 1'b1;
        m_valid   = 1'b0;
        m_held    = '{rob_id: ZERO_ROB, result: '0, src: SRC_A};
    endtask

    task automatic drive(input logic av, input ROB_ID_TYPE at, input DATA_TYPE ad,
                         input logic lv, input ROB_ID_TYPE lt, input DATA_TYPE ld);
        arith_valid  = av;
        arith_rob_id = at;
        arith_result = ad;
        ls_valid     = lv;
        ls_rob_id    = lt;
        ls_result    = ld;
    endtask

    task automatic idle();
        drive(1'b0, ZERO_ROB, '0, 1'b0, ZERO_ROB, '0);
    endtask

    // One clock: check readys mid-cycle, predict the edge, check the CDB after it.
    task automatic step();
        bit     a_acc;
        bit     l_acc;
        bit     fresh;
        bcast_t pop_e;
        @(negedge clk);
        check("arith_ready", arith_ready, rdy && (mq_a.size() < DEPTH));
        check("ls_ready",    ls_ready,    rdy && (mq_ls.size() < DEPTH));
        fresh = 0;
        if (misbranch_flag) begin
            mq_a.delete();
            mq_ls.delete();
            m_last_ls = 1'b1;
            m_valid   = 1'b0;
        end else if (rdy) begin
            a_acc = arith_valid && (mq_a.size() < DEPTH);
            l_acc = ls_valid && (mq_ls.size() < DEPTH);
            if (mq_a.size() > 0 && (mq_ls.size() == 0 || m_last_ls)) begin
                pop_e     = mq_a.pop_front();
                m_last_ls = 1'b0;
                fresh     = 1;
            end else if (mq_ls.size() > 0) begin
                pop_e     = mq_ls.pop_front();
                m_last_ls = 1'b1;
                fresh     = 1;
            end
            if (fresh) exp_q.push_back(pop_e);
            m_valid = fresh;
            if (a_acc && arith_rob_id != ZERO_ROB)
                mq_a.push_back('{rob_id: arith_rob_id, result: arith_result, src: SRC_A});
            if (l_acc && ls_rob_id != ZERO_ROB)
                mq_ls.push_back('{rob_id: ls_rob_id, result: ls_result, src: SRC_L});
        end
        @(posedge clk);
        #1;
        check("cdb_valid", cdb_valid, m_valid);
        if (cdb_valid === 1'b1 && exp_q.size() > 0) begin
            m_held = exp_q.pop_front();
        end
        check("cdb_rob_id", cdb_rob_id, m_held.rob_id);
        check("cdb_result", cdb_result, m_held.result);
        check("cdb_src",    cdb_src,    m_held.src);
    endtask

    initial begin
        rst            = 1'b0;
        rdy            = 1'b1;
        misbranch_flag = 1'b0;
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_cdb_valid",  cdb_valid,  0);
        check("reset_cdb_rob_id", cdb_rob_id, ZERO_ROB);
        check("reset_cdb_result", cdb_result, 0);
        check("reset_cdb_src",    cdb_src,    0);
        rst = 1'b1;
        step();

        // Single Arith result: pushed at edge N, broadcast at edge N+1.
        drive(1'b1, 4'd3, 32'h11, 1'b0, ZERO_ROB, '0);
        step();
        idle();
        step();
        check("single_rob_id", cdb_rob_id, 3);
        check("single_result", cdb_result, 32'h11);
        repeat (2) step();

        // Reset once more so the contention case starts from last_grant = LS.
        rst = 1'b0;
        #2;
        model_reset();
        rst = 1'b1;
        drive(1'b1, 4'd1, 32'hA, 1'b1, 4'd2, 32'hB);
        step();
        idle();
        repeat (3) step();

        // Both requesters continuously valid; each holds its data until accepted.
        begin
            ROB_ID_TYPE a_tag;
            ROB_ID_TYPE l_tag;
            bit         a_acc;
            bit         l_acc;
            a_tag = 4'd1;
            l_tag = 4'd8;
            for (int c = 0; c < 6; c++) begin
                drive(1'b1, a_tag, 32'h100 + DATA_TYPE'(a_tag), 1'b1, l_tag, 32'h200 + DATA_TYPE'(l_tag));
                a_acc = mq_a.size() < DEPTH;
                l_acc = mq_ls.size() < DEPTH;
                step();
                if (a_acc) a_tag = a_tag + 4'd1;
                if (l_acc) l_tag = l_tag + 4'd1;
            end
        end
        idle();
        repeat (5) step();

        // Load both queues, then flush with live inputs that must be dropped.
        drive(1'b1, 4'd3, 32'h33, 1'b1, 4'd5, 32'h55);
        step();
        drive(1'b0, ZERO_ROB, '0, 1'b1, 4'd6, 32'h66);
        step();
        drive(1'b1, 4'd7, 32'h77, 1'b1, 4'd9, 32'h99);
        misbranch_flag = 1'b1;
        step();
        misbranch_flag = 1'b0;
        idle();
        repeat (3) step();

        // Tag 0 handshakes but never reaches the bus.
        drive(1'b1, ZERO_ROB, 32'hDEAD, 1'b0, ZERO_ROB, '0);
        step();
        idle();
        repeat (2) step();

        // Freeze with entries queued, then resume.
        drive(1'b1, 4'd4, 32'h44, 1'b1, 4'd12, 32'hC0);
        step();
        drive(1'b1, 4'd5, 32'h45, 1'b1, 4'd13, 32'hC1);
        step();
        idle();
        rdy = 1'b0;
        repeat (3) step();
        rdy = 1'b1;
        repeat (5) step();

        // Asynchronous reset mid-operation discards queued entries.
        drive(1'b1, 4'd9, 32'h99, 1'b1, 4'd10, 32'hAA);
        repeat (2) step();
        rst = 1'b0;
        #2;
        check("midrst_cdb_valid",   cdb_valid,   0);
        check("midrst_cdb_rob_id",  cdb_rob_id,  ZERO_ROB);
        check("midrst_arith_ready", arith_ready, 1);
        check("midrst_ls_ready",    ls_ready,    1);
        model_reset();
        idle();
        rst = 1'b1;
        repeat (3) step();

        // Random traffic with occasional freezes and flushes.
        for (int c = 0; c < 400; c++) begin
            drive(1'($urandom_range(0, 1)), ROB_ID_TYPE'($urandom_range(0, 15)), DATA_TYPE'($urandom),
                  1'($urandom_range(0, 1)), ROB_ID_TYPE'($urandom_range(0, 15)), DATA_TYPE'($urandom));
            rdy            = ($urandom_range(0, 9) != 0);
            misbranch_flag = ($urandom_range(0, 29) == 0);
            step();
        end
        rdy            = 1'b1;
        misbranch_flag = 1'b0;
        idle();
        repeat (6) step();

        check("scoreboard_drained", exp_q.size(), 0);
        check("model_queues_empty", mq_a.size() + mq_ls.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
